// File: rtl/mandelbrot_mc_engine.sv
`default_nettype none
// ============================================================================
// Module      : mandelbrot_mc_engine
// Description : Multi-context Mandelbrot/Julia iterator. CTX jobs share one
//               escape-time datapath, visited round-robin; results leave tagged
//               and possibly out of order.
// Revision    : 1.0 - initial release
// ============================================================================
module mandelbrot_mc_engine #(
    parameter int FP_TOP = 8,
    parameter int FP_BOT = 24,
    parameter int CTX    = 4,
    parameter int TAG_W  = 16,
    parameter int ITER_W = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [ITER_W-1:0]          iterations_max,
    input  logic                       julia_en,
    input  logic [FP_TOP+FP_BOT-1:0]   julia_cx,
    input  logic [FP_TOP+FP_BOT-1:0]   julia_cy,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [FP_TOP+FP_BOT-1:0]   in_x0,
    input  logic [FP_TOP+FP_BOT-1:0]   in_y0,
    input  logic [TAG_W-1:0]           in_tag,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [TAG_W-1:0]           out_tag,
    output logic [ITER_W-1:0]          out_iterations,
    output logic                       out_escaped,
    output logic                       busy
);

    localparam int FP_BITS = FP_TOP + FP_BOT;
    localparam int IDX_W   = $clog2(CTX);
    localparam int ESC_W   = FP_BITS + 2;
    localparam logic [ESC_W-1:0] c_FOUR = ESC_W'(4) << FP_BOT;

    typedef enum logic [1:0] {
        S_FREE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } slot_state_t;

    slot_state_t          r_state [CTX];
    logic [FP_BITS-1:0]   r_x     [CTX];
    logic [FP_BITS-1:0]   r_y     [CTX];
    logic [FP_BITS-1:0]   r_cx    [CTX];
    logic [FP_BITS-1:0]   r_cy    [CTX];
    logic [ITER_W-1:0]    r_n     [CTX];
    logic [ITER_W-1:0]    r_imax  [CTX];
    logic [TAG_W-1:0]     r_tag   [CTX];
    logic                 r_esc   [CTX];
    logic [IDX_W-1:0]     r_ptr;

    logic                 r_out_valid;
    logic [TAG_W-1:0]     r_out_tag;
    logic [ITER_W-1:0]    r_out_iter;
    logic                 r_out_esc;

    logic                 w_any_free;
    logic                 w_any_done;
    logic                 w_any_busy;
    logic [IDX_W-1:0]     w_free_idx;
    logic [IDX_W-1:0]     w_done_idx;

    // Lowest-index FREE and DONE slots, taken from registered state only.
    always_comb begin
        w_any_free = 1'b0;
        w_any_done = 1'b0;
        w_any_busy = 1'b0;
        w_free_idx = '0;
        w_done_idx = '0;
        for (int i = CTX - 1; i >= 0; i--) begin
            if (r_state[i] == S_FREE) begin
                w_any_free = 1'b1;
                w_free_idx = IDX_W'(i);
            end else begin
                w_any_busy = 1'b1;
            end
            if (r_state[i] == S_DONE) begin
                w_any_done = 1'b1;
                w_done_idx = IDX_W'(i);
            end
        end
    end

    logic                 w_accept;
    logic                 w_out_load;
    logic                 w_step;
    assign w_accept   = in_valid && w_any_free;
    assign w_out_load = !r_out_valid || out_ready;
    assign w_step     = (r_state[r_ptr] == S_RUN);

    // Shared datapath operating on the slot under the round-robin pointer.
    logic [FP_BITS-1:0]   w_x, w_y;
    logic [2*FP_BITS-1:0] w_xx, w_yy, w_xy;
    logic [FP_BITS-1:0]   w_x2, w_y2, w_xys;
    logic [ESC_W-1:0]     w_mag;
    logic                 w_escape;
    logic                 w_limit;
    logic [FP_BITS-1:0]   w_xn, w_yn;

    assign w_x  = r_x[r_ptr];
    assign w_y  = r_y[r_ptr];
    assign w_xx = {{FP_BITS{w_x[FP_BITS-1]}}, w_x} * {{FP_BITS{w_x[FP_BITS-1]}}, w_x};
    assign w_yy = {{FP_BITS{w_y[FP_BITS-1]}}, w_y} * {{FP_BITS{w_y[FP_BITS-1]}}, w_y};
    assign w_xy = {{FP_BITS{w_x[FP_BITS-1]}}, w_x} * {{FP_BITS{w_y[FP_BITS-1]}}, w_y};
    assign w_x2  = w_xx[2*FP_BITS-FP_TOP-1:FP_BOT];
    assign w_y2  = w_yy[2*FP_BITS-FP_TOP-1:FP_BOT];
    assign w_xys = w_xy[2*FP_BITS-FP_TOP-1:FP_BOT];

    // Two guard bits keep x^2+y^2 from wrapping before the compare.
    assign w_mag    = {{2{w_x2[FP_BITS-1]}}, w_x2} + {{2{w_y2[FP_BITS-1]}}, w_y2};
    assign w_escape = ($signed(w_mag) >= $signed(c_FOUR));
    assign w_limit  = (r_n[r_ptr] >= r_imax[r_ptr]);
    assign w_xn     = w_x2 - w_y2 + r_cx[r_ptr];
    assign w_yn     = {w_xys[FP_BITS-2:0], 1'b0} + r_cy[r_ptr];

    logic w_unused;
    assign w_unused = ^{w_xx[2*FP_BITS-1:2*FP_BITS-FP_TOP], w_xx[FP_BOT-1:0],
                        w_yy[2*FP_BITS-1:2*FP_BITS-FP_TOP], w_yy[FP_BOT-1:0],
                        w_xy[2*FP_BITS-1:2*FP_BITS-FP_TOP], w_xy[FP_BOT-1:0],
                        w_xys[FP_BITS-1]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < CTX; i++) begin
                r_state[i] <= S_FREE;
                r_x[i]     <= '0;
                r_y[i]     <= '0;
                r_cx[i]    <= '0;
                r_cy[i]    <= '0;
                r_n[i]     <= '0;
                r_imax[i]  <= '0;
                r_tag[i]   <= '0;
                r_esc[i]   <= 1'b0;
            end
            r_ptr       <= '0;
            r_out_valid <= 1'b0;
            r_out_tag   <= '0;
            r_out_iter  <= '0;
            r_out_esc   <= 1'b0;
        end else begin
            r_ptr <= r_ptr + IDX_W'(1);

            // Accept, step and pickup always touch distinct slots: they
            // require FREE, RUN and DONE respectively.
            if (w_accept) begin
                r_state[w_free_idx] <= S_RUN;
                r_n[w_free_idx]     <= '0;
                r_imax[w_free_idx]  <= iterations_max;
                r_tag[w_free_idx]   <= in_tag;
                r_esc[w_free_idx]   <= 1'b0;
                if (julia_en) begin
                    r_x[w_free_idx]  <= in_x0;
                    r_y[w_free_idx]  <= in_y0;
                    r_cx[w_free_idx] <= julia_cx;
                    r_cy[w_free_idx] <= julia_cy;
                end else begin
                    r_x[w_free_idx]  <= '0;
                    r_y[w_free_idx]  <= '0;
                    r_cx[w_free_idx] <= in_x0;
                    r_cy[w_free_idx] <= in_y0;
                end
            end

            if (w_step) begin
                if (w_escape) begin
                    r_state[r_ptr] <= S_DONE;
                    r_esc[r_ptr]   <= 1'b1;
                end else if (w_limit) begin
                    r_state[r_ptr] <= S_DONE;
                    r_esc[r_ptr]   <= 1'b0;
                end else begin
                    r_x[r_ptr] <= w_xn;
                    r_y[r_ptr] <= w_yn;
                    r_n[r_ptr] <= r_n[r_ptr] + ITER_W'(1);
                end
            end

            if (w_out_load) begin
                if (w_any_done) begin
                    r_out_valid         <= 1'b1;
                    r_out_tag           <= r_tag[w_done_idx];
                    r_out_iter          <= r_n[w_done_idx];
                    r_out_esc           <= r_esc[w_done_idx];
                    r_state[w_done_idx] <= S_FREE;
                end else begin
                    r_out_valid <= 1'b0;
                end
            end
        end
    end

    assign in_ready       = w_any_free;
    assign out_valid      = r_out_valid;
    assign out_tag        = r_out_tag;
    assign out_iterations = r_out_iter;
    assign out_escaped    = r_out_esc;
    assign busy           = w_any_busy || r_out_valid;

endmodule
`default_nettype wire

// File: tb/tb_mandelbrot_mc_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_mandelbrot_mc_engine
// Description : Directed self-checking bench for mandelbrot_mc_engine.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mandelbrot_mc_engine;

    localparam int c_CTX = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] iterations_max = '0;
    logic        julia_en = 1'b0;
    logic [31:0] julia_cx = '0;
    logic [31:0] julia_cy = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_x0 = '0;
    logic [31:0] in_y0 = '0;
    logic [15:0] in_tag = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_tag;
    logic [31:0] out_iterations;
    logic        out_escaped;
    logic        busy;

    int total = 0;
    int bad   = 0;

    mandelbrot_mc_engine #(
        .FP_TOP(8), .FP_BOT(24), .CTX(c_CTX), .TAG_W(16), .ITER_W(32)
    ) dut (
        .clk(clk), .reset(reset),
        .iterations_max(iterations_max), .julia_en(julia_en),
        .julia_cx(julia_cx), .julia_cy(julia_cy),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_x0(in_x0), .in_y0(in_y0), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_tag(out_tag), .out_iterations(out_iterations),
        .out_escaped(out_escaped), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic set_job(input logic [15:0] tag, input logic [31:0] x0, input logic [31:0] y0,
                           input logic jen, input logic [31:0] jcx, input logic [31:0] jcy,
                           input logic [31:0] imax);
        in_tag = tag; in_x0 = x0; in_y0 = y0;
        julia_en = jen; julia_cx = jcx; julia_cy = jcy; iterations_max = imax;
    endtask

    // Offer the current job and hold it until the edge that accepts it.
    task automatic submit(input string name);
        int cyc = 0;
        in_valid = 1'b1;
        while (!in_ready && cyc < 200) begin
            @(posedge clk); #1; cyc++;
        end
        if (cyc >= 200) check({name, "_accept_timeout"}, 1'b0, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // One job on an idle engine: result fields plus the latency bound.
    task automatic run_job(input string name, input logic [15:0] tag,
                           input logic [31:0] x0, input logic [31:0] y0, input logic jen,
                           input logic [31:0] jcx, input logic [31:0] jcy, input logic [31:0] imax,
                           input logic [31:0] exp_n, input logic exp_esc);
        int lat = 0;
        out_ready = 1'b1;
        set_job(tag, x0, y0, jen, jcx, jcy, imax);
        submit(name);
        while (!out_valid && lat < 2000) begin
            @(posedge clk); #1; lat++;
        end
        if (lat >= 2000) begin
            check({name, "_result_timeout"}, 1'b0, 1'b1);
        end else begin
            check({name, "_tag"}, out_tag, tag);
            check({name, "_iter"}, out_iterations, exp_n);
            check({name, "_esc"}, out_escaped, exp_esc);
            check({name, "_latency_ok"}, (lat + 1) <= ((exp_n + 1) * c_CTX + 2), 1'b1);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        logic [7:0]  seen;
        logic [15:0] snap_tag;
        logic [15:0] order [2];
        int          accepted;
        int          nout;
        int          nxt;
        bit          snapped;

        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_tag", out_tag, 16'h0);
        check("rst_out_iter", out_iterations, 32'h0);
        check("rst_out_esc", out_escaped, 1'b0);
        reset = 1'b0;
        #1;
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        @(posedge clk); #1;

        // Mandelbrot origin stays bounded; c=1,2,-2 and 1.5 escape early.
        run_job("mb_origin", 16'h00A1, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 32'd10, 32'd10, 1'b0);
        run_job("mb_c1", 16'h00A2, 32'h01000000, 32'h0, 1'b0, 32'h0, 32'h0, 32'd50, 32'd2, 1'b1);
        run_job("mb_c2", 16'h00A3, 32'h02000000, 32'h0, 1'b0, 32'h0, 32'h0, 32'd50, 32'd1, 1'b1);
        run_job("mb_cm2", 16'h00A4, 32'hFE000000, 32'h0, 1'b0, 32'h0, 32'h0, 32'd50, 32'd1, 1'b1);
        run_job("mb_c15", 16'h00A5, 32'h01800000, 32'h0, 1'b0, 32'h0, 32'h0, 32'd50, 32'd2, 1'b1);
        run_job("ju_z15", 16'h00B1, 32'h01800000, 32'h0, 1'b1, 32'h0, 32'h0, 32'd50, 32'd1, 1'b1);
        // c=i cycles through i, -1+i, -i, -1+i ... and never escapes.
        run_job("ju_ci", 16'h00B2, 32'h0, 32'h0, 1'b1, 32'h0, 32'h01000000, 32'd20, 32'd20, 1'b0);
        run_job("imax0", 16'h00C1, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 32'd0, 32'd0, 1'b0);
        run_job("imax0_esc", 16'h00C2, 32'h02000000, 32'h0, 1'b1, 32'h0, 32'h0, 32'd0, 32'd0, 1'b1);

        // Capacity with the output stalled, then drain all eight tags.
        out_ready = 1'b0;
        set_job(16'd0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 32'd3);
        in_valid = 1'b1;
        accepted = 0; nxt = 0; seen = '0; nout = 0; snapped = 0; snap_tag = '0;
        for (int cyc = 0; cyc < 100; cyc++) begin
            if (out_valid && !snapped) begin
                snapped = 1; snap_tag = out_tag;
            end
            if (in_valid && in_ready) begin
                @(posedge clk); #1;
                accepted++; nxt++;
                in_tag = 16'(nxt);
                if (nxt == 8) in_valid = 1'b0;
            end else begin
                @(posedge clk); #1;
            end
        end
        check("cap_accepted", accepted, 5);
        check("cap_in_ready", in_ready, 1'b0);
        check("cap_out_valid", out_valid, 1'b1);
        check("cap_tag_stable", out_tag, snap_tag);
        check("cap_iter", out_iterations, 32'd3);
        check("cap_esc", out_escaped, 1'b0);
        check("cap_busy", busy, 1'b1);

        out_ready = 1'b1;
        for (int cyc = 0; cyc < 1000 && nout < 8; cyc++) begin
            logic acc;
            acc = in_valid && in_ready;
            if (out_valid) begin
                check("drain_iter", out_iterations, 32'd3);
                check("drain_tag_new", (out_tag < 8) && !seen[out_tag[2:0]], 1'b1);
                if (out_tag < 8) seen[out_tag[2:0]] = 1'b1;
                nout++;
            end
            @(posedge clk); #1;
            if (acc) begin
                nxt++;
                in_tag = 16'(nxt);
                if (nxt == 8) in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        check("drain_all_tags", seen, 8'hFF);
        check("drain_count", nout, 8);
        repeat (3) @(posedge clk); #1;
        check("drain_idle", busy, 1'b0);

        // Long job A then short job B: B must overtake A.
        out_ready = 1'b1;
        set_job(16'h0A0A, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 32'd200);
        submit("mix_a");
        set_job(16'h0B0B, 32'h02000000, 32'h0, 1'b0, 32'h0, 32'h0, 32'd200);
        submit("mix_b");
        nout = 0;
        for (int cyc = 0; cyc < 1500 && nout < 2; cyc++) begin
            if (out_valid) begin
                order[nout] = out_tag;
                check(nout == 0 ? "mix_first_iter" : "mix_second_iter", out_iterations,
                      nout == 0 ? 32'd1 : 32'd200);
                check(nout == 0 ? "mix_first_esc" : "mix_second_esc", out_escaped,
                      nout == 0 ? 1'b1 : 1'b0);
                nout++;
            end
            @(posedge clk); #1;
        end
        check("mix_count", nout, 2);
        if (nout == 2) begin
            check("mix_first_tag", order[0], 16'h0B0B);
            check("mix_second_tag", order[1], 16'h0A0A);
        end

        // Reset while three long jobs run and a result is waiting.
        out_ready = 1'b0;
        set_job(16'h0010, 32'h02000000, 32'h0, 1'b0, 32'h0, 32'h0, 32'd1000);
        submit("rst_j0");
        for (int k = 1; k < 4; k++) begin
            set_job(16'(16 + k), 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 32'd1000);
            submit("rst_jn");
        end
        for (int cyc = 0; cyc < 100 && !out_valid; cyc++) begin
            @(posedge clk); #1;
        end
        check("pre_rst_out_valid", out_valid, 1'b1);
        check("pre_rst_busy", busy, 1'b1);
        reset = 1'b1;
        @(posedge clk); #1;
        check("mid_rst_out_valid", out_valid, 1'b0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_in_ready", in_ready, 1'b1);
        check("mid_rst_out_tag", out_tag, 16'h0);
        reset = 1'b0;
        @(posedge clk); #1;
        run_job("post_rst", 16'h0055, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 32'd2, 32'd2, 1'b0);
        repeat (c_CTX * 4) @(posedge clk); #1;
        check("post_rst_no_stale", out_valid, 1'b0);
        check("post_rst_idle", busy, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
